// File: rtl/conv_window_gen.sv
// Sliding K x K window generator: raster pixel stream in, flattened windows out with ready/valid.
// Optional CONV_WIN_STRIDE_EN adds i_stride2 (latched at i_start) for stride-2 window emission.
module conv_window_gen #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int K     = 5,
    parameter int DW    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
`ifdef CONV_WIN_STRIDE_EN
    input  logic              i_stride2,
`endif
    input  logic              pixel_in_valid,
    input  logic [DW-1:0]     pixel_in,
    output logic              pixel_in_ready,
    output logic [K*K*DW-1:0] win_out,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [4:0]        o_window_col,
    output logic [4:0]        o_output_row,
    output logic              o_row_start,
    output logic              o_row_end,
    output logic              o_done
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_KM1    = CW'(K - 1);
    localparam logic [RW-1:0] ROW_KM1    = RW'(K - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [CW-1:0] WCOL_LAST  = CW'(IMG_W - K);
    localparam logic [CW-1:0] WCOL_LAST2 = CW'(((IMG_W - K) / 2) * 2);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_e;

    state_e                         state_q, state_d;
    logic [CW-1:0]                  in_col_q, in_col_d;
    logic [RW-1:0]                  in_row_q, in_row_d;
    logic                           all_in_q, all_in_d;
    logic                           stride_q, stride_d;
    logic [K-1:0][K-1:0][DW-1:0]    win_q, win_d;
    logic                           win_valid_q, win_valid_d;
    logic [4:0]                     wcol_q, wcol_d;
    logic [4:0]                     wrow_q, wrow_d;
    logic                           row_start_q, row_start_d;
    logic                           row_end_q, row_end_d;
    logic                           done_q, done_d;

    // lb_q[0] holds the previous row, lb_q[K-2] the oldest row still needed
    logic [DW-1:0]                  lb_q [K-1][IMG_W];
    logic [K-1:0][DW-1:0]           col_new;
    logic [CW-1:0]                  win_col;
    logic [RW-1:0]                  win_row;
    logic                           accept;
    logic                           active;

    assign active         = (state_q == FILL) || (state_q == RUN);
    assign pixel_in_ready = active && !all_in_q && !(win_valid_q && !win_ready);
    assign accept         = pixel_in_valid && pixel_in_ready;
    assign win_col        = in_col_q - COL_KM1;
    assign win_row        = in_row_q - ROW_KM1;

    // Incoming column, top row first; reads see pre-write (previous-row) data
    always_comb begin
        col_new = '0;
        col_new[K-1] = pixel_in;
        for (int i = 0; i < K - 1; i++) col_new[i] = lb_q[K-2-i][in_col_q];
    end

    always_comb begin
        state_d     = state_q;
        in_col_d    = in_col_q;
        in_row_d    = in_row_q;
        all_in_d    = all_in_q;
        stride_d    = stride_q;
        win_d       = win_q;
        win_valid_d = win_valid_q;
        wcol_d      = wcol_q;
        wrow_d      = wrow_q;
        row_start_d = row_start_q;
        row_end_d   = row_end_q;
        if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
            row_start_d = 1'b0;
            row_end_d   = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d  = FILL;
                    in_col_d = '0;
                    in_row_d = '0;
                    all_in_d = 1'b0;
`ifdef CONV_WIN_STRIDE_EN
                    stride_d = i_stride2;
`else
                    stride_d = 1'b0;
`endif
                end
            end
            FILL, RUN: begin
                if (accept) begin
                    for (int i = 0; i < K; i++) begin
                        for (int j = 0; j < K - 1; j++) win_d[i][j] = win_q[i][j+1];
                        win_d[i][K-1] = col_new[i];
                    end
                    if (in_col_q == COL_LAST) begin
                        in_col_d = '0;
                        if (in_row_q == ROW_LAST) all_in_d = 1'b1;
                        else                      in_row_d = in_row_q + RW'(1);
                    end else begin
                        in_col_d = in_col_q + CW'(1);
                    end
                    // Columns below K-1 would straddle the row wrap, so they never emit
                    if (in_row_q >= ROW_KM1 && in_col_q >= COL_KM1 &&
                        (!stride_q || (!win_col[0] && !win_row[0]))) begin
                        win_valid_d = 1'b1;
                        wcol_d      = 5'(win_col);
                        wrow_d      = 5'(win_row);
                        row_start_d = (win_col == '0);
                        row_end_d   = (win_col == (stride_q ? WCOL_LAST2 : WCOL_LAST));
                        state_d     = RUN;
                    end
                end
                if (all_in_d && !win_valid_d) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            in_col_q    <= '0;
            in_row_q    <= '0;
            all_in_q    <= 1'b0;
            stride_q    <= 1'b0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            wcol_q      <= '0;
            wrow_q      <= '0;
            row_start_q <= 1'b0;
            row_end_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_col_q    <= in_col_d;
            in_row_q    <= in_row_d;
            all_in_q    <= all_in_d;
            stride_q    <= stride_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
            wcol_q      <= wcol_d;
            wrow_q      <= wrow_d;
            row_start_q <= row_start_d;
            row_end_q   <= row_end_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < K - 1; j++)
                for (int a = 0; a < IMG_W; a++) lb_q[j][a] <= '0;
        end else if (accept) begin
            lb_q[0][in_col_q] <= pixel_in;
            for (int j = 1; j < K - 1; j++) lb_q[j][in_col_q] <= lb_q[j-1][in_col_q];
        end
    end

    assign win_out      = win_q;
    assign win_valid    = win_valid_q;
    assign o_window_col = wcol_q;
    assign o_output_row = wrow_q;
    assign o_row_start  = row_start_q;
    assign o_row_end    = row_end_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: ramp frames, stalls, stray starts, mid-frame reset.
module tb_conv_window_gen;
    localparam int IMG_W = 32;
    localparam int IMG_H = 32;
    localparam int K     = 5;
    localparam int DW    = 8;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int WW    = K * K * DW;

    typedef struct {
        logic [WW-1:0] win;
        int            col;
        int            row;
        bit            rs;
        bit            re;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_start = 1'b0;
`ifdef CONV_WIN_STRIDE_EN
    logic          i_stride2 = 1'b0;
`endif
    logic          pixel_in_valid = 1'b0;
    logic [DW-1:0] pixel_in = '0;
    logic          pixel_in_ready;
    logic [WW-1:0] win_out;
    logic          win_valid;
    logic          win_ready = 1'b0;
    logic [4:0]    o_window_col, o_output_row;
    logic          o_row_start, o_row_end, o_done;

    conv_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start),
`ifdef CONV_WIN_STRIDE_EN
        .i_stride2(i_stride2),
`endif
        .pixel_in_valid(pixel_in_valid), .pixel_in(pixel_in), .pixel_in_ready(pixel_in_ready),
        .win_out(win_out), .win_valid(win_valid), .win_ready(win_ready),
        .o_window_col(o_window_col), .o_output_row(o_output_row),
        .o_row_start(o_row_start), .o_row_end(o_row_end), .o_done(o_done)
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0, err_cnt = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int tot_acc = 0, tot_wins = 0, tot_done = 0;
    int acc_base = 0, win_base = 0;
    bit in_frame = 1'b0;
    logic [WW-1:0] win0, win1;
    int col1, w92_col, w92_row;

    task automatic check(input string name, input longint act, input longint exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_w(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] ref_win(input int orow, input int ocol);
        logic [WW-1:0] w = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                w[(i*K+j)*DW +: DW] = DW'((orow + i) * IMG_W + (ocol + j));
        return w;
    endfunction

    task automatic push_expected(input bit stride);
        exp_t e;
        int lastc = stride ? ((IMG_W - K) / 2) * 2 : IMG_W - K;
        for (int r = 0; r <= IMG_H - K; r++)
            for (int c = 0; c <= IMG_W - K; c++)
                if (!stride || (r % 2 == 0 && c % 2 == 0)) begin
                    e.win = ref_win(r, c);
                    e.col = c;
                    e.row = r;
                    e.rs  = (c == 0);
                    e.re  = (c == lastc);
                    exp_q.push_back(e);
                end
    endtask

    // Monitor: pops the scoreboard on every window handshake, checks ready each cycle
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            if (in_frame)
                check("pixel_in_ready", pixel_in_ready,
                      ((tot_acc - acc_base) < NPIX) && !(win_valid && !win_ready));
            if (win_valid && win_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_window", tot_wins - win_base, -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_w("win_out", win_out, mon_e.win);
                    check("o_window_col", o_window_col, mon_e.col);
                    check("o_output_row", o_output_row, mon_e.row);
                    check("o_row_start", o_row_start, mon_e.rs);
                    check("o_row_end", o_row_end, mon_e.re);
                end
                if (tot_wins - win_base == 0) win0 = win_out;
                if (tot_wins - win_base == 1) begin win1 = win_out; col1 = o_window_col; end
                if (tot_wins - win_base == 92) begin w92_col = o_window_col; w92_row = o_output_row; end
                tot_wins++;
            end
            if (o_done) tot_done++;
            if (pixel_in_valid && pixel_in_ready) tot_acc++;
        end
    end

    // mode 0: free-running, 1: win_ready 1-of-3, 2: stray valid/start, 3: reset at rst_at windows
    task automatic run_frame(input int mode, input bit stride, input int rst_at);
        int idx = 0, cyc = 0, n_exp, done_base;
        bit first = 1'b0, acc, aborted = 1'b0;
        logic [WW-1:0] t;
        push_expected(stride);
        n_exp = exp_q.size();
        acc_base = tot_acc; win_base = tot_wins; done_base = tot_done;
        if (mode == 2) begin
            pixel_in_valid = 1'b1; pixel_in = 8'hAA;
            repeat (4) begin
                @(negedge clk);
                check("ready_before_start", pixel_in_ready, 0);
                @(posedge clk); #1;
            end
        end
`ifdef CONV_WIN_STRIDE_EN
        i_stride2 = stride;
`endif
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        in_frame = 1'b1;
        while (tot_done == done_base) begin
            if (cyc >= 8000) begin
                check("frame_done_within_budget", tot_done - done_base, 1);
                break;
            end
            pixel_in_valid = (idx < NPIX);
            pixel_in       = DW'(idx);
            win_ready      = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
            i_start        = (mode == 2 && cyc == 200);
            @(negedge clk);
            acc = pixel_in_valid && pixel_in_ready;
            #2;
            if (mode == 0 && !first && win_valid) begin
                first = 1'b1;
                check("accepts_at_first_valid", idx, 133);
            end
            if (rst_at >= 0 && tot_wins - win_base >= rst_at) begin
                reset_n = 1'b0;
                #1;
                check("rst_win_valid", win_valid, 0);
                check("rst_pixel_in_ready", pixel_in_ready, 0);
                check_w("rst_win_out", win_out, '0);
                check("rst_o_window_col", o_window_col, 0);
                check("rst_o_output_row", o_output_row, 0);
                check("rst_o_row_start", o_row_start, 0);
                check("rst_o_row_end", o_row_end, 0);
                check("rst_o_done", o_done, 0);
                in_frame = 1'b0;
                pixel_in_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1 reset_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        pixel_in_valid = 1'b0;
        i_start = 1'b0;
        win_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        in_frame = 1'b0;
        if (!aborted) begin
            check("windows_per_frame", tot_wins - win_base, n_exp);
            check("pixels_accepted", tot_acc - acc_base, NPIX);
            check("done_pulses", tot_done - done_base, 1);
            check("scoreboard_empty", exp_q.size(), 0);
            if (mode == 0 && !stride) begin
                t = win0;
                check("win0_elem00", t[0 +: DW], 8'h00);
                check("win0_elem44", t[(4*K+4)*DW +: DW], 8'h84);
                check("win92_row", w92_row, 3);
                check("win92_col", w92_col, 8);
            end
            if (stride) begin
                t = win1;
                check("stride_win1_col", col1, 2);
                check("stride_win1_elem00", t[0 +: DW], 8'h02);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_win_valid", win_valid, 0);
        check("reset_pixel_in_ready", pixel_in_ready, 0);
        check("reset_o_done", o_done, 0);
        check_w("reset_win_out", win_out, '0);
        check("reset_o_window_col", o_window_col, 0);
        reset_n = 1'b1;
        pixel_in_valid = 1'b1;
        @(posedge clk); #1;
        check("idle_pixel_in_ready", pixel_in_ready, 0);
        pixel_in_valid = 1'b0;
        run_frame(0, 1'b0, -1);
        run_frame(1, 1'b0, -1);
        run_frame(2, 1'b0, -1);
        run_frame(3, 1'b0, 300);
        run_frame(0, 1'b0, -1);
`ifdef CONV_WIN_STRIDE_EN
        run_frame(0, 1'b1, -1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
